// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and default widths for the sequential left shifter
// Purpose: FSM state encoding and default parameter values.
// Ports:   none (package).
package shifter_pkg;

   localparam int NB_BITS_DATA_DEFAULT  = 32;
   localparam int NB_BITS_SHIFT_DEFAULT = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_state_t;

endpackage

// File: rtl/configurable_mux.sv
// rtl/configurable_mux.sv - N-input one-hot-free select mux over a flattened input bus
// Purpose: returns slice sel_i of data_i; out-of-range selects return 0.
// Ports:   data_i [nb_inputs*nb_bits_data] flattened inputs (slice 0 = LSBs),
//          sel_i [nb_sel] select, data_o [nb_bits_data] selected slice.
module configurable_mux #(
   parameter int nb_bits_data = 32,
   parameter int nb_inputs    = 2,
   parameter int nb_sel       = 1
) (
   input  logic [nb_inputs*nb_bits_data-1:0] data_i,
   input  logic [nb_sel-1:0]                 sel_i,
   output logic [nb_bits_data-1:0]           data_o
);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < nb_inputs; i++) begin
         if (sel_i == nb_sel'(i)) begin
            data_o = data_i[i*nb_bits_data +: nb_bits_data];
         end
      end
   end

endmodule

// File: rtl/fixed_shifter_left_logical.sv
// rtl/fixed_shifter_left_logical.sv - conditional left shift by a constant amount
// Purpose: data_o = enable_i ? data_i << shift_value : data_i (zero fill).
// Ports:   data_i [nb_bits_data] operand, enable_i apply the shift,
//          data_o [nb_bits_data] result.
module fixed_shifter_left_logical #(
   parameter int nb_bits_data = 32,
   parameter int shift_value  = 1
) (
   input  logic [nb_bits_data-1:0] data_i,
   input  logic                    enable_i,
   output logic [nb_bits_data-1:0] data_o
);

   logic [nb_bits_data-1:0]   w_shifted;
   logic [2*nb_bits_data-1:0] w_mux_in;

   assign w_shifted = data_i << shift_value;
   assign w_mux_in  = {w_shifted, data_i};

   configurable_mux #(
      .nb_bits_data (nb_bits_data),
      .nb_inputs    (2),
      .nb_sel       (1)
   ) u_sel (
      .data_i (w_mux_in),
      .sel_i  (enable_i),
      .data_o (data_o)
   );

endmodule

// File: rtl/sequential_shifter_left_logical.sv
// rtl/sequential_shifter_left_logical.sv - multi-cycle left logical shifter, one power-of-two stage per clock
// Purpose: SLL/SLLI execute unit; start/ready request, one-cycle valid_o result pulse.
// Optional: SHIFTER_LEFT_EARLY_EXIT_EN finishes once no higher shamt bits remain.
// Ports:   clk_i clock, rst_i sync active-high reset,
//          start_i request (taken when ready_o), data_i operand, shamt_i shift amount,
//          ready_o idle/done, valid_o result pulse, data_o result register.
// nb_bits_shift must satisfy 2**nb_bits_shift == nb_bits_data.
module sequential_shifter_left_logical
   import shifter_pkg::*;
#(
   parameter int nb_bits_data  = NB_BITS_DATA_DEFAULT,
   parameter int nb_bits_shift = NB_BITS_SHIFT_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [nb_bits_data-1:0]  data_i,
   input  logic [nb_bits_shift-1:0] shamt_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [nb_bits_data-1:0]  data_o
);

   localparam int CW = (nb_bits_shift > 1) ? $clog2(nb_bits_shift) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(nb_bits_shift - 1);

   shift_state_t             r_state;
   logic [nb_bits_data-1:0]  r_data;
   logic [nb_bits_shift-1:0] r_shamt;
   logic [CW-1:0]            r_cnt;
   logic                     r_ready;
   logic                     r_valid;
   logic [nb_bits_data-1:0]  r_data_out;

   logic [nb_bits_shift*nb_bits_data-1:0] w_stage_bus;
   logic [nb_bits_data-1:0]               w_stage_out;
   logic                                  w_last;

   // Every stage sees the same r_data; only the stage picked by r_cnt is used.
   for (genvar k = 0; k < nb_bits_shift; k++) begin : g_stage
      fixed_shifter_left_logical #(
         .nb_bits_data (nb_bits_data),
         .shift_value  (1 << k)
      ) u_stage (
         .data_i   (r_data),
         .enable_i (r_shamt[k]),
         .data_o   (w_stage_bus[k*nb_bits_data +: nb_bits_data])
      );
   end

   configurable_mux #(
      .nb_bits_data (nb_bits_data),
      .nb_inputs    (nb_bits_shift),
      .nb_sel       (CW)
   ) u_stage_sel (
      .data_i (w_stage_bus),
      .sel_i  (r_cnt),
      .data_o (w_stage_out)
   );

`ifdef SHIFTER_LEFT_EARLY_EXIT_EN
   logic [nb_bits_shift-1:0] w_rest;
   // Bits above the current stage all clear: nothing left to apply.
   assign w_rest = r_shamt >> (r_cnt + CW'(1));
   assign w_last = (r_cnt == LAST_CNT) || (w_rest == '0);
`else
   assign w_last = (r_cnt == LAST_CNT);
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_ready    <= 1'b1;
         r_valid    <= 1'b0;
         r_data_out <= '0;
         r_cnt      <= '0;
         r_data     <= '0;
         r_shamt    <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_data  <= data_i;
                  r_shamt <= shamt_i;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_data <= w_stage_out;
               r_cnt  <= r_cnt + CW'(1);
               if (w_last) begin
                  r_data_out <= w_stage_out;
                  r_valid    <= 1'b1;
                  r_ready    <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               // A start here begins the next operation with no idle gap.
               if (start_i) begin
                  r_data  <= data_i;
                  r_shamt <= shamt_i;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_state <= SHIFT;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o = r_ready;
   assign valid_o = r_valid;
   assign data_o  = r_data_out;

endmodule

// File: tb/tb_sequential_shifter_left_logical.sv
// tb/tb_sequential_shifter_left_logical.sv - scoreboard bench for sequential_shifter_left_logical
module tb_sequential_shifter_left_logical;

   localparam int NBD = 32;
   localparam int NBS = 5;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           start_i;
   logic [NBD-1:0] data_i;
   logic [NBS-1:0] shamt_i;
   logic           ready_o;
   logic           valid_o;
   logic [NBD-1:0] data_o;

   sequential_shifter_left_logical #(
      .nb_bits_data  (NBD),
      .nb_bits_shift (NBS)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .data_i  (data_i),
      .shamt_i (shamt_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [NBD-1:0] data;
      int             cyc;
   } exp_t;

   exp_t           sb[$];
   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   logic [NBD-1:0] exp_last = '0;
   logic           prev_valid = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic int model_latency(input int s);
`ifdef SHIFTER_LEFT_EARLY_EXIT_EN
      int h = 0;
      for (int i = 0; i < NBS; i++) if (((s >> i) & 1) == 1) h = i;
      return 2 + h;
`else
      return NBS + 1;
`endif
   endfunction

   task automatic check(input string name, input logic [NBD-1:0] act, input logic [NBD-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every valid pulse.
   always @(negedge clk_i) begin
      if (valid_o === 1'b1) begin
         check("valid_width", {31'b0, prev_valid}, 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=%h expected=no_pulse", data_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", data_o, e.data);
            check("latency_cycle", cyc, e.cyc);
            exp_last = e.data;
         end
      end else if (rst_i !== 1'b1) begin
         check("data_hold", data_o, exp_last);
      end
      prev_valid = valid_o;
   end

   // Caller is at posedge+#1; returns at posedge+#1 one cycle after acceptance.
   task automatic issue(input logic [NBD-1:0] d, input logic [NBS-1:0] s);
      int w = 0;
      logic [NBD-1:0] r;
      while (ready_o !== 1'b1 && w < 50) begin
         @(posedge clk_i); #1;
         w++;
      end
      if (ready_o !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=%b expected=1", ready_o);
         return;
      end
      start_i = 1'b1;
      data_i  = d;
      shamt_i = s;
      r = d << s;
      sb.push_back('{r, cyc + model_latency(int'(s))});
      @(posedge clk_i); #1;
      start_i = 1'b0;
      data_i  = $urandom;
      shamt_i = NBS'($urandom);
      check("ready_low_in_shift", {31'b0, ready_o}, 32'd0);
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() > 0 && w < 100) begin
         @(posedge clk_i); #1;
         w++;
      end
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      check("drain_empty", sb.size(), 32'd0);
   endtask

   initial begin
      rst_i   = 1'b1;
      start_i = 1'b0;
      data_i  = '0;
      shamt_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_ready", {31'b0, ready_o}, 32'd1);
      check("reset_valid", {31'b0, valid_o}, 32'd0);
      check("reset_data", data_o, 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      issue(32'h0000_0001, 5'd31);
      drain();

      // A start while busy must be dropped, not queued.
      issue(32'hDEAD_BEEF, 5'd4);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      data_i  = 32'h1111_1111;
      shamt_i = 5'd1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      drain();

      // Second issue lands in DONE; latency check proves no idle gap.
      issue(32'h0F0F_0F0F, 5'd8);
      issue(32'hFFFF_FFFF, 5'd16);
      drain();

      issue(32'h1234_5678, 5'd0);
      issue(32'h1234_5678, 5'd1);
      issue(32'h1234_5678, 5'd3);
      drain();

      // Abort in the third SHIFT cycle.
      issue(32'hA5A5_0F0F, 5'd31);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      sb.delete();
      exp_last = '0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      check("abort_valid", {31'b0, valid_o}, 32'd0);
      check("abort_data", data_o, 32'd0);
      check("abort_ready", {31'b0, ready_o}, 32'd1);
      repeat (8) begin
         @(posedge clk_i); #1;
      end
      issue(32'hCAFE_F00D, 5'd7);
      drain();

      for (int n = 0; n < 300; n++) begin
         logic [NBD-1:0] d;
         d = $urandom;
         for (int s = 0; s < 32; s++) issue(d, NBS'(s));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
